// File: rtl/reminder_pkg.sv
// Shared definitions for the multi-dose reminder: channel state encoding and missed-count width.
// Missed counters exist only when MISSED_COUNT_EN is defined.
package reminder_pkg;

  localparam int MISS_W = 4;

  typedef logic [1:0] chan_state_t;

  localparam chan_state_t ST_IDLE     = 2'd0;
  localparam chan_state_t ST_COUNTING = 2'd1;
  localparam chan_state_t ST_DUE      = 2'd2;

endpackage

// File: rtl/reminder_channel.sv
// One medicine channel: interval register, countdown and IDLE/COUNTING/DUE state.
// Optional saturating missed-dose counter when MISSED_COUNT_EN is defined.
module reminder_channel
  import reminder_pkg::*;
#(
  parameter int CNT_W            = 12,
  parameter int DEFAULT_INTERVAL = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             selected,
  input  logic             enable_pulse,
  input  logic             ack_pulse,
  input  logic             load_pulse,
  input  logic [CNT_W-1:0] interval_in,
  output logic             enabled,
  output logic             due
`ifdef MISSED_COUNT_EN
  ,
  output logic [MISS_W-1:0] missed
`endif
);

  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic             expire;

  // A countdown of 0 (interval rewritten to 0 mid-count) expires like 1 instead of wrapping.
  assign expire = tick && (cnt_q <= CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    interval_d = interval_q;
    if (selected && load_pulse) begin
      interval_d = interval_in;
    end
    if (selected && enable_pulse && (interval_q != '0)) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_COUNTING;
        cnt_d   = interval_q;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (ack_pulse && (state_q == ST_DUE)) begin
      state_d = ST_COUNTING;
      cnt_d   = interval_q;
    end else if (tick && (state_q != ST_IDLE)) begin
      if (expire) begin
        state_d = ST_DUE;
        cnt_d   = interval_q;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

`ifdef MISSED_COUNT_EN
  logic [MISS_W-1:0] missed_q, missed_d;

  // Only an expiry while already DUE counts as a missed dose.
  always_comb begin
    missed_d = missed_q;
    if (state_d == ST_IDLE) begin
      missed_d = '0;
    end else if ((state_q == ST_DUE) && (state_d == ST_DUE) && expire && (missed_q != '1)) begin
      missed_d = missed_q + MISS_W'(1);
    end
  end

  assign missed = missed_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      interval_q <= CNT_W'(DEFAULT_INTERVAL);
`ifdef MISSED_COUNT_EN
      missed_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      interval_q <= interval_d;
`ifdef MISSED_COUNT_EN
      missed_q   <= missed_d;
`endif
    end
  end

  assign enabled = (state_q != ST_IDLE);
  assign due     = (state_q == ST_DUE);

endmodule

// File: rtl/multi_dose_reminder.sv
// Multi-channel dose reminder top: tick prescaler, channel selection and per-channel instances.
// Define MISSED_COUNT_EN to expose the selected channel's missed-dose count on missed_sel.
module multi_dose_reminder
  import reminder_pkg::*;
#(
  parameter int NUM_MEDS         = 4,
  parameter int CNT_W            = 12,
  parameter int PRESCALE         = 60000,
  parameter int DEFAULT_INTERVAL = 480
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        select_pulse,
  input  logic                        enable_pulse,
  input  logic                        ack_pulse,
  input  logic                        load_pulse,
  input  logic [CNT_W-1:0]            interval_in,
  output logic [$clog2(NUM_MEDS)-1:0] sel_idx,
  output logic [NUM_MEDS-1:0]         enabled,
  output logic [NUM_MEDS-1:0]         due,
  output logic                        alarm,
  output logic                        tick,
  output logic [MISS_W-1:0]           missed_sel
);

  localparam int SEL_W = $clog2(NUM_MEDS);
  localparam int PRE_W = $clog2(PRESCALE);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  assign tick = (presc_q == PRE_W'(PRESCALE - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    sel_d   = sel_q;
    if (select_pulse) begin
      sel_d = (sel_q == SEL_W'(NUM_MEDS - 1)) ? '0 : sel_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      sel_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
    end
  end

  assign sel_idx = sel_q;

`ifdef MISSED_COUNT_EN
  logic [MISS_W-1:0] missed_all [NUM_MEDS];
`endif

  // Channels see the pre-increment selection, so a same-cycle select never retargets enable/load.
  for (genvar i = 0; i < NUM_MEDS; i++) begin : g_chan
    reminder_channel #(
      .CNT_W            (CNT_W),
      .DEFAULT_INTERVAL (DEFAULT_INTERVAL)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .selected     (sel_q == SEL_W'(i)),
      .enable_pulse (enable_pulse),
      .ack_pulse    (ack_pulse),
      .load_pulse   (load_pulse),
      .interval_in  (interval_in),
      .enabled      (enabled[i]),
      .due          (due[i])
`ifdef MISSED_COUNT_EN
      ,
      .missed       (missed_all[i])
`endif
    );
  end

  assign alarm = |due;

`ifdef MISSED_COUNT_EN
  assign missed_sel = missed_all[sel_q];
`else
  assign missed_sel = '0;
`endif

endmodule

// File: doc/multi_dose_reminder.md
MULTI_DOSE_REMINDER -- requirements
Module: multi_dose_reminder

Interface
REQ-001 Parameters SHALL be one per line:
- NUM_MEDS, 4, number of medicine channels (2..16).
- CNT_W, 12, interval/countdown width in ticks.
- PRESCALE, 60000, clk cycles per tick (>=2).
- DEFAULT_INTERVAL, 480, reset value of every interval register (nonzero).
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- select_pulse  in  1  one-cycle shaped press; advances selected channel.
- enable_pulse  in  1  one-cycle shaped press; toggles selected channel enable.
- ack_pulse  in  1  one-cycle shaped press; acknowledges alarms.
- load_pulse  in  1  one-cycle strobe; writes interval_in to selected channel.
- interval_in  in  CNT_W  interval value for load_pulse.
- sel_idx  out  $clog2(NUM_MEDS)  selected channel.
- enabled  out  NUM_MEDS  per-channel enable.
- due  out  NUM_MEDS  per-channel dose due.
- alarm  out  1  OR of due.
- tick  out  1  one-cycle prescaler strobe.
- missed_sel  out  4  missed count of selected channel (see REQ-016).

Function
REQ-003 Prescaler SHALL count 0..PRESCALE-1 and assert tick for one cycle when at PRESCALE-1, then wrap to 0.
REQ-004 select_pulse SHALL increment sel_idx, wrapping NUM_MEDS-1 -> 0, effective the next cycle.
REQ-005 Each channel SHALL hold states IDLE, COUNTING, DUE and a countdown register.
REQ-006 enable_pulse on selected IDLE channel SHALL load countdown from its interval register and enter COUNTING; on selected COUNTING/DUE channel SHALL enter IDLE and clear due.
REQ-007 enable_pulse SHALL be ignored when the selected interval register is 0.
REQ-008 In COUNTING on tick: countdown==1 -> enter DUE, reload countdown; else decrement.
REQ-009 due[i] SHALL assert the cycle after the tick that expires the countdown; alarm SHALL be combinational OR of due (same cycle).
REQ-010 In DUE, countdown SHALL keep decrementing on tick; a second expiry SHALL reload countdown and remain DUE.
REQ-011 ack_pulse SHALL move every DUE channel to COUNTING with countdown reloaded to full interval; COUNTING/IDLE channels are unaffected.
REQ-012 load_pulse SHALL update only the interval register of the selected channel; the new value takes effect at the next load/reload, not mid-count.
REQ-013 Simultaneous events on one channel, priority: enable_pulse > ack_pulse > tick.
REQ-014 select_pulse with enable_pulse/load_pulse in the same cycle: enable/load SHALL act on the pre-increment sel_idx.

Reset
REQ-015 On clk edge with reset low: sel_idx=0, enabled=0, due=0, alarm=0, tick=0, prescaler=0, countdowns=0, all channels IDLE, intervals=DEFAULT_INTERVAL, missed counts=0; reset mid-count SHALL abandon all countdowns.

Configuration
REQ-016 With MISSED_COUNT_EN defined: each channel SHALL own a 4-bit counter incrementing (saturating at 15) on each REQ-010 re-expiry, cleared when the channel enters IDLE, retained over ack; missed_sel shows the selected channel's count. Without it: no counters, missed_sel tied to 0.

Structure
REQ-017 Package reminder_pkg SHALL hold the channel state typedef (IDLE/COUNTING/DUE) and MISS_W=4.
REQ-018 Per-channel logic SHALL be sub-module reminder_channel, instantiated NUM_MEDS times by generate; prescaler and select logic stay in the top.

Verification (PRESCALE=4, CNT_W=8, NUM_MEDS=4)
REQ-019 Reset, then enable_pulse with interval 3 on ch0 -> enabled=0001; due[0] rises one cycle after the 3rd tick; alarm same cycle.
REQ-020 Four select_pulses from reset -> sel_idx 1,2,3,0.
REQ-021 ch0 DUE, ack_pulse and tick same cycle -> due[0]=0, countdown=3 (tick ignored).
REQ-022 load_pulse interval_in=5 on COUNTING ch1 (interval 2) -> current expiry after 2 ticks, next after 5.
REQ-023 MISSED_COUNT_EN, ch0 interval 2 left DUE for 6 ticks -> missed_sel=3; 20 re-expiries -> 15; enable_pulse -> 0.
REQ-024 load_pulse interval_in=0 then enable_pulse -> channel stays IDLE, enabled unchanged.
